conv_sequencer: RTL and testbench
=================================

Name: conv_sequencer

Overview:
- Control/address sequencer for the C1 convolution layer (32x32 image, 6 filters of 5x5, 28x28 outputs per filter).
- Walks every (filter, row, col) output position and, for each, steps through the Kernel*Kernel taps.
- Drives image-buffer and kernel-ROM read addresses and a shared MAC unit (clear/enable), then hands each finished result to the output buffer over a valid/ready handshake.
- Sits between the top-level CNN control (start/done) and the convolution datapath.

Parameters:
- DATA_WIDTH, 16, datapath word width (used only for the documentation of downstream widths)
- ImgInW, 32, input image width
- ImgInH, 32, input image height
- ConvOut, 28, output feature-map side (= ImgInW-Kernel+1)
- Kernel, 5, kernel side
- DepthC, 6, number of filters
- MacLat, 2, MAC pipeline latency in cycles from the last mac_en to a valid result

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a full layer pass; sampled only in IDLE
- busy  out  1  high in FETCH/DRAIN/WRITE
- done  out  1  one-cycle pulse after the last output is accepted
- img_addr  out  $clog2(ImgInW*ImgInH)  image buffer read address
- ker_addr  out  $clog2(Kernel*Kernel*DepthC)  kernel ROM read address
- mac_en  out  1  MAC accepts the current tap this cycle
- mac_clear  out  1  with mac_en: load the product instead of accumulating
- out_valid  out  1  MAC result at out_addr ready to be written
- out_ready  in  1  output buffer accepts the write
- out_addr  out  $clog2(ConvOut*ConvOut*DepthC)  output buffer write address

Behaviour:
- Reset (async, active-low): state=IDLE, all counters 0; busy, done, mac_en, mac_clear and out_valid are 0; all addresses are 0.
- Loop order, outer to inner: f (0..DepthC-1), row (0..ConvOut-1), col (0..ConvOut-1), kr (0..Kernel-1), kc (0..Kernel-1).
- img_addr = (row+kr)*ImgInW + (col+kc).
- ker_addr = f*Kernel*Kernel + kr*Kernel + kc.
- out_addr = f*ConvOut*ConvOut + row*ConvOut + col.
- All arithmetic is unsigned and computed at full width, with no truncation.
- States:
  - IDLE: start=1 goes to FETCH with all counters at 0. start=0 stays in IDLE.
  - FETCH: lasts exactly Kernel*Kernel cycles. mac_en=1 every cycle. mac_clear=1 only on the tap kr=0, kc=0. kc/kr advance each cycle. After the last tap, go to DRAIN.
  - DRAIN: lasts exactly MacLat cycles with mac_en=0. Then go to WRITE.
  - WRITE: out_valid=1 and out_addr is held stable until out_ready=1. On the handshake, advance col/row/f and go to FETCH. If the handshake is on the last position, go to DONE instead.
  - DONE: lasts one cycle. done=1, busy=0. Then go to IDLE.
- Address outputs are registered and change only on tap or position advance.
- Cycle cost per output is Kernel*Kernel + MacLat + (WRITE cycles). With out_ready tied high this is 25+2+1 = 28 cycles.
- start while busy or in DONE is ignored.
- out_ready held low stalls WRITE indefinitely; no counter moves while stalled.
- Counter wrap: when kc reaches Kernel-1 it wraps to 0 and increments kr; col, row and f wrap and carry the same way. f wrapping past DepthC-1 signals the end of the pass.
- Reset asserted mid-pass aborts immediately to IDLE with no done pulse.

Optional Feature:
- Macro: CONV_SEQ_PERF_CNT_EN.
- When defined: adds output stall_cycles [31:0], a count of cycles spent in WRITE with out_ready=0. It is cleared to 0 when start is accepted, saturates at 32'hFFFFFFFF, holds its value after done, and resets to 0.
- When undefined: the port and the counter are absent; behaviour is otherwise identical.

Decomposition:
- Package conv_pkg holds:
  - the state enum (IDLE, FETCH, DRAIN, WRITE, DONE);
  - localparams for the address widths (IMG_AW, KER_AW, OUT_AW) and per-output cycle cost;
  - the layer-geometry defaults.
- Sub-module conv_addr_gen holds the nested kc/kr/col/row/f counters with advance_tap/advance_pos inputs, wrap flags, and the three address computations. The FSM stays in conv_sequencer.

Test Plan:
- Small config (ImgInW=ImgInH=6, ConvOut=4, Kernel=3, DepthC=2, MacLat=2), out_ready=1, start pulse at cycle 0 -> busy high for exactly 32*12=384 cycles, done pulses once, 32 writes with out_addr 0..31 in order.
- Same config, first output -> img_addr sequence 0,1,2,6,7,8,12,13,14; ker_addr 0..8; mac_clear only on the first tap; mac_en low for 2 cycles before out_valid.
- Same config, position f=1, row=3, col=3 -> out_addr=31, first img_addr=21, first ker_addr=9, last img_addr=35.
- Hold out_ready=0 for 5 cycles at output 7 -> out_valid and out_addr=7 stable for 6 cycles, total busy 389 cycles; with CONV_SEQ_PERF_CNT_EN, stall_cycles=5.
- Assert reset low during FETCH of output 10 -> all outputs return to 0 asynchronously, no done pulse; a new start runs a full pass from out_addr 0.
- start pulsed again while busy -> ignored, exactly one done pulse, 32 writes.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: state encoding, default C1 geometry and address widths shared by the conv sequencer.
package conv_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} conv_state_e;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_IMG_IN_W   = 32;
    localparam int DEF_IMG_IN_H   = 32;
    localparam int DEF_CONV_OUT   = 28;
    localparam int DEF_KERNEL     = 5;
    localparam int DEF_DEPTH_C    = 6;
    localparam int DEF_MAC_LAT    = 2;

    localparam int IMG_AW = $clog2(DEF_IMG_IN_W * DEF_IMG_IN_H);
    localparam int KER_AW = $clog2(DEF_KERNEL * DEF_KERNEL * DEF_DEPTH_C);
    localparam int OUT_AW = $clog2(DEF_CONV_OUT * DEF_CONV_OUT * DEF_DEPTH_C);

    function automatic int out_cycles(input int kernel, input int mac_lat);
        return kernel * kernel + mac_lat + 1;
    endfunction

    localparam int OUT_CYCLES = out_cycles(DEF_KERNEL, DEF_MAC_LAT);

endpackage

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: nested kc/kr/col/row/f counters with registered image, kernel and output addresses.
module conv_addr_gen import conv_pkg::*; #(
    parameter int ImgInW  = DEF_IMG_IN_W,
    parameter int ConvOut = DEF_CONV_OUT,
    parameter int Kernel  = DEF_KERNEL,
    parameter int DepthC  = DEF_DEPTH_C,
    parameter int IAW     = IMG_AW,
    parameter int KAW     = KER_AW,
    parameter int OAW     = OUT_AW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear_i,
    input  logic           adv_tap_i,
    input  logic           adv_pos_i,
    output logic           tap_first_o,
    output logic           tap_last_o,
    output logic           pos_last_o,
    output logic [IAW-1:0] img_addr_o,
    output logic [KAW-1:0] ker_addr_o,
    output logic [OAW-1:0] out_addr_o
);

    localparam int KW = $clog2(Kernel + 1);
    localparam int PW = $clog2(ConvOut + 1);
    localparam int FW = $clog2(DepthC + 1);

    logic [KW-1:0]  kc_q, kc_d, kr_q, kr_d;
    logic [PW-1:0]  col_q, col_d, row_q, row_d;
    logic [FW-1:0]  f_q, f_d;
    logic [IAW-1:0] img_d;
    logic [KAW-1:0] ker_d;
    logic [OAW-1:0] out_d;
    logic           kc_wrap, kr_wrap, col_wrap, row_wrap, f_wrap;

    assign kc_wrap     = kc_q == KW'(Kernel - 1);
    assign kr_wrap     = kr_q == KW'(Kernel - 1);
    assign col_wrap    = col_q == PW'(ConvOut - 1);
    assign row_wrap    = row_q == PW'(ConvOut - 1);
    assign f_wrap      = f_q == FW'(DepthC - 1);
    assign tap_first_o = kc_q == '0 && kr_q == '0;
    assign tap_last_o  = kc_wrap && kr_wrap;
    assign pos_last_o  = col_wrap && row_wrap && f_wrap;

    always_comb begin
        kc_d  = kc_q;
        kr_d  = kr_q;
        col_d = col_q;
        row_d = row_q;
        f_d   = f_q;
        if (clear_i) begin
            kc_d  = '0;
            kr_d  = '0;
            col_d = '0;
            row_d = '0;
            f_d   = '0;
        end else begin
            if (adv_tap_i) begin
                kc_d = kc_wrap ? '0 : kc_q + 1'b1;
                kr_d = kc_wrap ? (kr_wrap ? '0 : kr_q + 1'b1) : kr_q;
            end
            if (adv_pos_i) begin
                col_d = col_wrap ? '0 : col_q + 1'b1;
                row_d = col_wrap ? (row_wrap ? '0 : row_q + 1'b1) : row_q;
                f_d   = (col_wrap && row_wrap) ? (f_wrap ? '0 : f_q + 1'b1) : f_q;
            end
        end
        // Addresses are formed at 32 bits from the next counters so the registers track them exactly.
        img_d = IAW'((32'(row_d) + 32'(kr_d)) * 32'(ImgInW) + 32'(col_d) + 32'(kc_d));
        ker_d = KAW'(32'(f_d) * 32'(Kernel * Kernel) + 32'(kr_d) * 32'(Kernel) + 32'(kc_d));
        out_d = OAW'(32'(f_d) * 32'(ConvOut * ConvOut) + 32'(row_d) * 32'(ConvOut) + 32'(col_d));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kc_q       <= '0;
            kr_q       <= '0;
            col_q      <= '0;
            row_q      <= '0;
            f_q        <= '0;
            img_addr_o <= '0;
            ker_addr_o <= '0;
            out_addr_o <= '0;
        end else begin
            kc_q       <= kc_d;
            kr_q       <= kr_d;
            col_q      <= col_d;
            row_q      <= row_d;
            f_q        <= f_d;
            img_addr_o <= img_d;
            ker_addr_o <= ker_d;
            out_addr_o <= out_d;
        end
    end

endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer: C1 convolution control FSM driving image/kernel reads, the MAC and output writes.
// Optional CONV_SEQ_PERF_CNT_EN adds a saturating stall_cycles counter of WRITE cycles without out_ready.
module conv_sequencer import conv_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ImgInW     = DEF_IMG_IN_W,
    parameter int ImgInH     = DEF_IMG_IN_H,
    parameter int ConvOut    = DEF_CONV_OUT,
    parameter int Kernel     = DEF_KERNEL,
    parameter int DepthC     = DEF_DEPTH_C,
    parameter int MacLat     = DEF_MAC_LAT,
    localparam int IAW = $clog2(ImgInW * ImgInH),
    localparam int KAW = $clog2(Kernel * Kernel * DepthC),
    localparam int OAW = $clog2(ConvOut * ConvOut * DepthC)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [IAW-1:0] img_addr,
    output logic [KAW-1:0] ker_addr,
    output logic           mac_en,
    output logic           mac_clear,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OAW-1:0] out_addr
`ifdef CONV_SEQ_PERF_CNT_EN
    ,output logic [31:0]   stall_cycles
`endif
);

    localparam int LW = $clog2(MacLat + 1);

    if (ConvOut != ImgInW - Kernel + 1 || DATA_WIDTH < 1 || MacLat < 1) begin : g_bad_geometry
        $error("conv_sequencer: inconsistent geometry parameters");
    end

    conv_state_e state_q, state_d;
    logic [LW-1:0] drain_q, drain_d;
    logic clear, adv_tap, adv_pos, tap_first, tap_last, pos_last;

    conv_addr_gen #(
        .ImgInW (ImgInW),
        .ConvOut(ConvOut),
        .Kernel (Kernel),
        .DepthC (DepthC),
        .IAW    (IAW),
        .KAW    (KAW),
        .OAW    (OAW)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (reset),
        .clear_i    (clear),
        .adv_tap_i  (adv_tap),
        .adv_pos_i  (adv_pos),
        .tap_first_o(tap_first),
        .tap_last_o (tap_last),
        .pos_last_o (pos_last),
        .img_addr_o (img_addr),
        .ker_addr_o (ker_addr),
        .out_addr_o (out_addr)
    );

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        clear     = 1'b0;
        adv_tap   = 1'b0;
        adv_pos   = 1'b0;
        mac_en    = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                clear   = start;
                state_d = start ? FETCH : IDLE;
            end
            FETCH: begin
                mac_en  = 1'b1;
                adv_tap = 1'b1;
                drain_d = '0;
                state_d = tap_last ? DRAIN : FETCH;
            end
            DRAIN: begin
                drain_d = drain_q + 1'b1;
                state_d = drain_q == LW'(MacLat - 1) ? WRITE : DRAIN;
            end
            WRITE: begin
                out_valid = 1'b1;
                adv_pos   = out_ready;
                state_d   = !out_ready ? WRITE : pos_last ? DONE : FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mac_clear = mac_en && tap_first;
    assign busy      = state_q == FETCH || state_q == DRAIN || state_q == WRITE;
    assign done      = state_q == DONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

`ifdef CONV_SEQ_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;

    assign stall_d = (state_q == IDLE && start) ? '0 :
                     (state_q == WRITE && !out_ready && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    assign stall_cycles = stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_q <= '0;
        else        stall_q <= stall_d;
    end
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: scoreboard bench for conv_sequencer on a small 6x6 / 3x3 / 2-filter layer.
// Build with CONV_SEQ_PERF_CNT_EN defined to also check stall_cycles.
module tb_conv_sequencer;

    localparam int W    = 6;
    localparam int H    = 6;
    localparam int CO   = 4;
    localparam int K    = 3;
    localparam int D    = 2;
    localparam int LAT  = 2;
    localparam int NPOS = CO * CO * D;
    localparam int NTAP = K * K;

    logic clk = 1'b0, reset = 1'b0, start = 1'b0, out_ready = 1'b1;
    logic busy, done, mac_en, mac_clear, out_valid;
    logic [$clog2(W*H)-1:0]     img_addr;
    logic [$clog2(K*K*D)-1:0]   ker_addr;
    logic [$clog2(CO*CO*D)-1:0] out_addr;
`ifdef CONV_SEQ_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    conv_sequencer #(
        .DATA_WIDTH(16), .ImgInW(W), .ImgInH(H), .ConvOut(CO),
        .Kernel(K), .DepthC(D), .MacLat(LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .img_addr(img_addr), .ker_addr(ker_addr), .mac_en(mac_en),
        .mac_clear(mac_clear), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr)
`ifdef CONV_SEQ_PERF_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {int img; int ker; bit clr;} tap_t;
    tap_t tap_q[$];
    int   exp_q[$];
    tap_t t;
    int checks = 0, failures = 0;
    int busy_cnt = 0, done_cnt = 0, wr_cnt = 0, stall_cnt = 0, since_en = 0;
    int ready_mode = 0, stall_left = 0;
    bit prev_valid = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: every position in f/row/col order, each with its taps in kr/kc order.
    task automatic load_model();
        exp_q.delete();
        tap_q.delete();
        for (int f = 0; f < D; f++)
            for (int r = 0; r < CO; r++)
                for (int c = 0; c < CO; c++) begin
                    exp_q.push_back(f * CO * CO + r * CO + c);
                    for (int kr = 0; kr < K; kr++)
                        for (int kc = 0; kc < K; kc++)
                            tap_q.push_back('{(r + kr) * W + c + kc, f * K * K + kr * K + kc, kr == 0 && kc == 0});
                end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (out_valid) begin
                if (!prev_valid) check("drain_gap", since_en, LAT);
                if (exp_q.size() == 0) check("write_extra", 1, 0);
                else begin
                    check("out_addr", int'(out_addr), exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        wr_cnt++;
                    end
                end
                if (!out_ready) stall_cnt++;
            end
            if (mac_en) begin
                if (tap_q.size() == 0) check("tap_extra", 1, 0);
                else begin
                    t = tap_q.pop_front();
                    check("img_addr", int'(img_addr), t.img);
                    check("ker_addr", int'(ker_addr), t.ker);
                    check("mac_clear", int'(mac_clear), int'(t.clr));
                end
                since_en = 0;
            end else begin
                if (mac_clear) check("mac_clear_no_en", 1, 0);
                since_en++;
            end
            prev_valid = out_valid;
        end
    end

    always @(posedge clk) begin
        #2;
        if (ready_mode == 0) out_ready = 1'b1;
        else if (ready_mode == 1) begin
            if (out_valid && wr_cnt == 7 && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else out_ready = 1'b1;
        end else out_ready = $urandom_range(0, 3) != 0;
    end

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_mac_en"}, int'(mac_en), 0);
        check({tag, "_mac_clear"}, int'(mac_clear), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_img_addr"}, int'(img_addr), 0);
        check({tag, "_ker_addr"}, int'(ker_addr), 0);
        check({tag, "_out_addr"}, int'(out_addr), 0);
    endtask

    task automatic begin_pass(input int mode);
        load_model();
        busy_cnt = 0; done_cnt = 0; wr_cnt = 0; stall_cnt = 0;
        stall_left = 5; ready_mode = mode; prev_valid = 1'b0;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic run_pass(input string tag, input int mode, input bit restart, input int exp_stalls);
        begin_pass(mode);
        if (restart) begin
            repeat (50) @(posedge clk);
            #2 start = 1'b1;
            @(posedge clk); #2 start = 1'b0;
        end
        for (int i = 0; i < 5000 && done_cnt == 0; i++) @(posedge clk);
        check({tag, "_done_seen"}, int'(done_cnt > 0), 1);
        repeat (3) @(posedge clk);
        #2;
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_writes"}, wr_cnt, NPOS);
        check({tag, "_exp_left"}, exp_q.size(), 0);
        check({tag, "_taps_left"}, tap_q.size(), 0);
        check({tag, "_busy_cycles"}, busy_cnt, NPOS * (NTAP + LAT + 1) + stall_cnt);
        check({tag, "_busy_after"}, int'(busy), 0);
        if (exp_stalls >= 0) check({tag, "_stalls"}, stall_cnt, exp_stalls);
`ifdef CONV_SEQ_PERF_CNT_EN
        check({tag, "_stall_cycles"}, int'(stall_cycles), stall_cnt);
`endif
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset");
        reset = 1'b1;
        run_pass("basic", 0, 1'b0, 0);
        run_pass("stall", 1, 1'b0, 5);
        begin_pass(0);
        for (int i = 0; i < 2000 && !(wr_cnt == 10 && mac_en); i++) begin
            @(posedge clk); #2;
        end
        check("abort_wr_cnt", wr_cnt, 10);
        check("abort_out_addr", int'(out_addr), 10);
        reset = 1'b0;
        #1;
        check_zero("abort");
        repeat (3) @(posedge clk);
        #2;
        exp_q.delete();
        tap_q.delete();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("abort_no_done", done_cnt, 0);
        run_pass("after_abort", 0, 1'b0, 0);
        run_pass("restart", 0, 1'b1, 0);
        run_pass("rand1", 2, 1'b0, -1);
        run_pass("rand2", 2, 1'b0, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
